// File: rtl/transmitter_fifo.sv
// transmitter_fifo: DEPTH-entry transmit buffer between the host write port
// and the UART Transmitter Shift Register. Words leave through a registered
// data_out with a one-cycle data_load strobe, the same handshake the old
// single-entry holding register used. Also provides a level count, a
// low-water flag (thre), a sticky overflow flag and a synchronous flush.
module transmitter_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int THRESH     = 2,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  signal_wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  tsr_ready,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_load,
  output logic                  signal_ready,
  output logic                  fifo_empty,
  output logic [ADDR_W:0]       level,
  output logic                  thre,
  output logic                  overflow
);

  localparam int LEVEL_W = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_reg;
  logic [ADDR_W-1:0]     rd_ptr_reg;
  logic [LEVEL_W-1:0]    level_reg;
  logic [LEVEL_W-1:0]    level_next;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  data_load_reg;
  logic                  overflow_reg;

  logic full;
  logic empty;
  logic do_push;
  logic do_pop;
  logic push_rejected;

  // Full/empty come from the level register at cycle start, so a pop in the
  // same cycle never frees room for a push and an empty FIFO never bypasses.
  assign full          = (level_reg == LEVEL_W'(DEPTH));
  assign empty         = (level_reg == '0);
  assign do_push       = signal_wr_en && !full && !flush;
  assign do_pop        = tsr_ready && !empty && !flush;
  assign push_rejected = signal_wr_en && full && !flush;

  // Status outputs are decoded purely from the level register.
  assign signal_ready = !full;
  assign fifo_empty   = empty;
  assign level        = level_reg;
  assign thre         = (level_reg <= LEVEL_W'(THRESH));
  assign data_out     = data_out_reg;
  assign data_load    = data_load_reg;
  assign overflow     = overflow_reg;

  // Next occupancy: flush clears, a simultaneous push and pop cancel out.
  always_comb begin
    level_next = level_reg;
    if (flush) begin
      level_next = '0;
    end else if (do_push && !do_pop) begin
      level_next = level_reg + LEVEL_W'(1);
    end else if (do_pop && !do_push) begin
      level_next = level_reg - LEVEL_W'(1);
    end
  end

  // Storage array write port; contents need no reset since level guards reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Pointers and level; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      level_reg <= level_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (do_push) begin
          wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
        end
        if (do_pop) begin
          rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
        end
      end
    end
  end

  // Registered read toward the TSR with a one-cycle load strobe per word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_reg  <= '0;
      data_load_reg <= 1'b0;
    end else begin
      data_load_reg <= do_pop;
      if (do_pop) begin
        data_out_reg <= mem[rd_ptr_reg];
      end
    end
  end

  // Sticky overflow: a rejected push sets it and beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (push_rejected) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

endmodule
